// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int DATA_W              = 32;
  localparam int DEPTH_WORDS_DEFAULT = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  typedef enum logic {
    SZ_WORD = 1'b0,
    SZ_BYTE = 1'b1
  } size_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath request bus and data-memory port of the load/store unit.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic              req_byte;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // Environment side: datapath issues requests, memory returns read data.
  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, mem_rd,
    input  stall, ld_data, mem_a, mem_wd, mem_we
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_rd,
    output stall, ld_data, mem_a, mem_wd, mem_we
  );

endinterface

// File: rtl/byte_lane.sv
// Byte extract (load path) and byte merge (store path) by little-endian lane.
module byte_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_in,
  input  logic [1:0]        lane,
  input  logic [7:0]        byte_in,
  output logic [7:0]        byte_out,
  output logic [DATA_W-1:0] word_out
);

  // Lane 0 is bits [7:0]; the merged word keeps the other three lanes.
  always_comb begin
    byte_out               = word_in[8*lane +: 8];
    word_out               = word_in;
    word_out[8*lane +: 8]  = byte_in;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word loads/stores pass through, byte loads zero-extend,
// byte stores become a two-cycle read-modify-write, bad accesses are flagged.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  load_store_unit_if.slave       bus,
  output logic                   fault,
  output logic [DATA_W-1:0]      fault_addr
);

  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(4 * DEPTH_WORDS);

  state_e            state;
  logic [DATA_W-1:0] rmw_addr;
  logic [DATA_W-1:0] rmw_word;

  size_e             size;
  logic              out_of_range;
  logic              misaligned;
  logic              bad;
  logic              accept;
  logic              start_rmw;
  logic [7:0]        lane_byte;
  logic [DATA_W-1:0] merged_word;

  logic              stall_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] ld_data_c;
  logic [DATA_W-1:0] mem_a_c;
  logic [DATA_W-1:0] mem_wd_c;

  byte_lane u_byte_lane (
    .word_in  (bus.mem_rd),
    .lane     (bus.req_addr[1:0]),
    .byte_in  (bus.req_wdata[7:0]),
    .byte_out (lane_byte),
    .word_out (merged_word)
  );

  // Classify the live request; range is checked before alignment.
  always_comb begin
    size         = size_e'(bus.req_byte);
    out_of_range = (bus.req_addr >= ADDR_LIMIT);
    misaligned   = (size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00);
    bad          = bus.req_valid && (out_of_range || misaligned);
    accept       = (state == IDLE) && bus.req_valid && !bad;
    start_rmw    = accept && bus.req_write && (size == SZ_BYTE);
  end

  // Combinational bus outputs; reset forces write enable and stall low.
  always_comb begin
    stall_c   = 1'b0;
    mem_we_c  = 1'b0;
    ld_data_c = '0;
    mem_a_c   = bus.req_addr;
    mem_wd_c  = bus.req_wdata;
    if (state == RMW_WR) begin
      mem_we_c = 1'b1;
      mem_a_c  = rmw_addr;
      mem_wd_c = rmw_word;
    end else if (accept) begin
      unique case ({bus.req_write, size})
        {1'b0, SZ_WORD}: ld_data_c = bus.mem_rd;
        {1'b0, SZ_BYTE}: ld_data_c = {24'b0, lane_byte};
        {1'b1, SZ_WORD}: mem_we_c  = 1'b1;
        {1'b1, SZ_BYTE}: stall_c   = 1'b1;
        default:         ;
      endcase
    end
    if (!reset) begin
      stall_c  = 1'b0;
      mem_we_c = 1'b0;
    end
  end

  assign bus.stall   = stall_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.ld_data = ld_data_c;
  assign bus.mem_a   = mem_a_c;
  assign bus.mem_wd  = mem_wd_c;

  // Control state: RMW sequencing and the sticky first-fault record.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_rmw) state <= RMW_WR;
          if (bad && !fault) begin
            fault      <= 1'b1;
            fault_addr <= bus.req_addr;
          end
        end
        RMW_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the merged word and its address for the write-back cycle.
  always_ff @(posedge clk) begin
    if (start_rmw) begin
      rmw_addr <= bus.req_addr;
      rmw_word <= merged_word;
    end
  end

endmodule
